point_cloud_feeder: RTL and testbench
=====================================

// Module: point_cloud_feeder
// PURPOSE
//  Hardware counterpart to the outlier Controller. Holds the point cloud (x/y/z) in on-chip
//  memory, loaded over a stream. Serves Controller-side point requests (cache_x/y/z from
//  point_pos) and a cycling M-point neighbour window (cache_feeder_x/y/z). After done, drains
//  the Controller's outlier FIFO and emits the outlier coordinates on a valid/ready stream.
// PARAMETERS
//  N           16     coordinate / index width (bits)
//  M           32     points per feeder window
//  CORE_NUMBER 2      points per cache_x/y/z request
//  MAX_POINTS  32768  memory depth; ADDR_W = $clog2(MAX_POINTS)
// PORTS
//  clock             in   1            system clock, rising edge
//  reset             in   1            synchronous, active-high
//  load_valid        in   1            load beat valid
//  load_ready        out  1            block accepts load beat
//  load_x/y/z        in   N each       coordinates of loaded point
//  load_last         in   1            final point of cloud
//  point_cloud_size  out  ADDR_W+1     number of points loaded
//  ctrl_reset        out  1            reset to Controller; high until load complete
//  point_pos         in   N            Controller request index
//  cache_x/y/z       out  N*CORE_NUMBER  points point_pos..point_pos+CORE_NUMBER-1
//  cache_feeder_x/y/z out N*M          window feeder_pos..feeder_pos+M-1
//  feeder_pos        out  ADDR_W       window base index
//  done              in   1            Controller finished
//  empty             in   1            outlier FIFO empty
//  read_fifo         out  1            FIFO read strobe
//  outlier_pos       in   N            FIFO data, valid cycle after read_fifo
//  out_valid / out_ready  out / in  1  outlier stream handshake
//  out_x/y/z         out  N each       outlier coordinates
//  finished          out  1            sticky: drain complete
//  run_cycles        out  32           RUN cycle count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state LOAD, count=0, ctrl_reset=1, read_fifo/out_valid/finished=0, feeder_pos=0,
//    caches 0, run_cycles=0. Memory contents not cleared. Reset mid-operation aborts all.
//  - Packing: lowest index in MS slot, e.g. cache_x[N*CORE_NUMBER-1 -: N]=x[point_pos].
//    Any slot with index >= point_cloud_size outputs 0 (no wrap).
//  - LOAD: load_ready=1; beat on valid&ready writes mem[count], count++. load_last or
//    count==MAX_POINTS-1 accepted -> RUN next cycle; point_cloud_size=final count.
//  - RUN: ctrl_reset=0. cache_x/y/z registered from point_pos, 1-cycle latency.
//    feeder_pos advances each cycle: next = (feeder_pos+M >= size) ? 0 : feeder_pos+M;
//    cache_feeder_* registered from current feeder_pos. done=1 -> DRAIN.
//  - DRAIN: read_fifo pulses 1 cycle only when !empty, no read in flight, out_valid=0.
//    Cycle after: outlier_pos captured, coordinates fetched, out_valid=1 next cycle.
//    out_valid/out_x/y/z held stable until out_ready. outlier_pos >= size -> coords 0.
//    empty & no read in flight & !out_valid -> FINISH.
//  - FINISH: finished=1, all strobes 0, feeder frozen; leaves only on reset.
//  - load_valid ignored outside LOAD; done ignored outside RUN.
// CONFIGURATION
//  FEEDER_PERF_CNT_EN defined: run_cycles counts cycles in RUN, saturates at 2^32-1, held
//  after RUN. Undefined: run_cycles tied to 0, no counter logic.
// TESTING
//  1 Load 5 pts x=1..5, load_last on 5th -> size=5; ctrl_reset drops cycle after last beat.
//  2 size=5, CORE_NUMBER=2, point_pos=3 -> cache_x=0x0004_0005 next cycle; pos=4 -> 0x0005_0000.
//  3 size=70, M=32 -> feeder_pos 0,32,64,0,...; window@64: 6 valid slots, 26 zero slots.
//  4 done=1, FIFO holds 2,0 -> two read_fifo pulses; out x[2] then x[0]; out_ready low 3
//    cycles holds data stable; then finished=1.
//  5 reset=1 during RUN -> next cycle LOAD, size=0, ctrl_reset=1, load_ready=1.
//  6 FEEDER_PERF_CNT_EN on, RUN 100 cycles -> run_cycles=100; macro off -> run_cycles=0.

Source files
------------

// File: rtl/point_cloud_feeder.sv
// Point-cloud store and feeder for the outlier Controller: stream load, request/window serving, outlier drain.
// Optional FEEDER_PERF_CNT_EN: enables the saturating RUN-cycle counter on run_cycles.
module point_cloud_feeder #(
   parameter int unsigned N           = 16,
   parameter int unsigned M           = 32,
   parameter int unsigned CORE_NUMBER = 2,
   parameter int unsigned MAX_POINTS  = 32768,
   parameter int unsigned ADDR_W      = $clog2(MAX_POINTS)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     load_valid,
   output logic                     load_ready,
   input  logic [N-1:0]             load_x,
   input  logic [N-1:0]             load_y,
   input  logic [N-1:0]             load_z,
   input  logic                     load_last,
   output logic [ADDR_W:0]          point_cloud_size,
   output logic                     ctrl_reset,
   input  logic [N-1:0]             point_pos,
   output logic [N*CORE_NUMBER-1:0] cache_x,
   output logic [N*CORE_NUMBER-1:0] cache_y,
   output logic [N*CORE_NUMBER-1:0] cache_z,
   output logic [N*M-1:0]           cache_feeder_x,
   output logic [N*M-1:0]           cache_feeder_y,
   output logic [N*M-1:0]           cache_feeder_z,
   output logic [ADDR_W-1:0]        feeder_pos,
   input  logic                     done,
   input  logic                     empty,
   output logic                     read_fifo,
   input  logic [N-1:0]             outlier_pos,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_x,
   output logic [N-1:0]             out_y,
   output logic [N-1:0]             out_z,
   output logic                     finished,
   output logic [31:0]              run_cycles
);

   localparam int unsigned CW = N * CORE_NUMBER;
   localparam int unsigned WW = N * M;
   localparam int unsigned PW = 3 * N;

   typedef enum logic [1:0] {S_LOAD, S_RUN, S_DRAIN, S_FINISH} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W:0]     count_q, count_d;
   logic [CW-1:0]       cache_x_q, cache_x_d, cache_y_q, cache_y_d, cache_z_q, cache_z_d;
   logic [WW-1:0]       cf_x_q, cf_x_d, cf_y_q, cf_y_d, cf_z_q, cf_z_d;
   logic [ADDR_W-1:0]   feeder_pos_q, feeder_pos_d;
   logic                read_fifo_q, read_fifo_d;
   logic                wait_q, wait_d;
   logic                out_valid_q, out_valid_d;
   logic [N-1:0]        out_x_q, out_x_d, out_y_q, out_y_d, out_z_q, out_z_d;
   logic                finished_q, finished_d;
   logic                wr_en;
   logic [PW-1:0]       mem [MAX_POINTS];

   // Indices at or beyond the loaded size read as zero; no wrap-around.
   function automatic logic [PW-1:0] fetch(input logic [31:0] idx, input logic [ADDR_W:0] size);
      logic [PW-1:0] r;
      r = '0;
      if (idx < 32'(size)) r = mem[idx[ADDR_W-1:0]];
      return r;
   endfunction

   always_comb begin
      logic [PW-1:0] p;
      state_d      = state_q;
      count_d      = count_q;
      cache_x_d    = cache_x_q;
      cache_y_d    = cache_y_q;
      cache_z_d    = cache_z_q;
      cf_x_d       = cf_x_q;
      cf_y_d       = cf_y_q;
      cf_z_d       = cf_z_q;
      feeder_pos_d = feeder_pos_q;
      read_fifo_d  = 1'b0;
      wait_d       = 1'b0;
      out_valid_d  = out_valid_q;
      out_x_d      = out_x_q;
      out_y_d      = out_y_q;
      out_z_d      = out_z_q;
      finished_d   = finished_q;
      wr_en        = 1'b0;
      p            = '0;
      case (state_q)
         S_LOAD: begin
            if (load_valid && !reset) begin
               wr_en   = 1'b1;
               count_d = count_q + 1'b1;
               if (load_last || count_q == (ADDR_W+1)'(MAX_POINTS - 1)) state_d = S_RUN;
            end
         end
         S_RUN: begin
            for (int unsigned i = 0; i < CORE_NUMBER; i++) begin
               p = fetch(32'(point_pos) + i, count_q);
               cache_x_d[N*(CORE_NUMBER-i)-1 -: N] = p[PW-1 -: N];
               cache_y_d[N*(CORE_NUMBER-i)-1 -: N] = p[2*N-1 -: N];
               cache_z_d[N*(CORE_NUMBER-i)-1 -: N] = p[N-1:0];
            end
            for (int unsigned i = 0; i < M; i++) begin
               p = fetch(32'(feeder_pos_q) + i, count_q);
               cf_x_d[N*(M-i)-1 -: N] = p[PW-1 -: N];
               cf_y_d[N*(M-i)-1 -: N] = p[2*N-1 -: N];
               cf_z_d[N*(M-i)-1 -: N] = p[N-1:0];
            end
            if (32'(feeder_pos_q) + M >= 32'(count_q)) feeder_pos_d = '0;
            else                                       feeder_pos_d = feeder_pos_q + ADDR_W'(M);
            if (done) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // read_fifo_q marks the request cycle, wait_q the cycle outlier_pos is valid.
            wait_d = read_fifo_q;
            if (wait_q) begin
               p           = fetch(32'(outlier_pos), count_q);
               out_valid_d = 1'b1;
               out_x_d     = p[PW-1 -: N];
               out_y_d     = p[2*N-1 -: N];
               out_z_d     = p[N-1:0];
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
            end
            if (!read_fifo_q && !wait_q && !out_valid_q) begin
               if (!empty) read_fifo_d = 1'b1;
               else begin
                  state_d    = S_FINISH;
                  finished_d = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (wr_en) mem[count_q[ADDR_W-1:0]] <= {load_x, load_y, load_z};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_LOAD;
         count_q      <= '0;
         cache_x_q    <= '0;
         cache_y_q    <= '0;
         cache_z_q    <= '0;
         cf_x_q       <= '0;
         cf_y_q       <= '0;
         cf_z_q       <= '0;
         feeder_pos_q <= '0;
         read_fifo_q  <= 1'b0;
         wait_q       <= 1'b0;
         out_valid_q  <= 1'b0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         out_z_q      <= '0;
         finished_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         cache_x_q    <= cache_x_d;
         cache_y_q    <= cache_y_d;
         cache_z_q    <= cache_z_d;
         cf_x_q       <= cf_x_d;
         cf_y_q       <= cf_y_d;
         cf_z_q       <= cf_z_d;
         feeder_pos_q <= feeder_pos_d;
         read_fifo_q  <= read_fifo_d;
         wait_q       <= wait_d;
         out_valid_q  <= out_valid_d;
         out_x_q      <= out_x_d;
         out_y_q      <= out_y_d;
         out_z_q      <= out_z_d;
         finished_q   <= finished_d;
      end
   end

`ifdef FEEDER_PERF_CNT_EN
   logic [31:0] run_cycles_q, run_cycles_d;

   always_comb begin
      run_cycles_d = run_cycles_q;
      if (state_q == S_RUN && run_cycles_q != '1) run_cycles_d = run_cycles_q + 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset) run_cycles_q <= '0;
      else       run_cycles_q <= run_cycles_d;
   end

   assign run_cycles = run_cycles_q;
`else
   assign run_cycles = '0;
`endif

   assign load_ready       = (state_q == S_LOAD);
   assign ctrl_reset       = (state_q == S_LOAD);
   assign point_cloud_size = count_q;
   assign cache_x          = cache_x_q;
   assign cache_y          = cache_y_q;
   assign cache_z          = cache_z_q;
   assign cache_feeder_x   = cf_x_q;
   assign cache_feeder_y   = cf_y_q;
   assign cache_feeder_z   = cf_z_q;
   assign feeder_pos       = feeder_pos_q;
   assign read_fifo        = read_fifo_q;
   assign out_valid        = out_valid_q;
   assign out_x            = out_x_q;
   assign out_y            = out_y_q;
   assign out_z            = out_z_q;
   assign finished         = finished_q;

endmodule

// File: tb/tb_point_cloud_feeder.sv
// Randomized self-checking bench for point_cloud_feeder against a queue-based point-cloud model.
module tb_point_cloud_feeder;
   localparam int N = 16, M = 32, CN = 2, MAXP = 32768, AW = 15;

   logic            clock, reset;
   logic            load_valid, load_ready, load_last;
   logic [N-1:0]    load_x, load_y, load_z;
   logic [AW:0]     point_cloud_size;
   logic            ctrl_reset;
   logic [N-1:0]    point_pos;
   logic [N*CN-1:0] cache_x, cache_y, cache_z;
   logic [N*M-1:0]  cache_feeder_x, cache_feeder_y, cache_feeder_z;
   logic [AW-1:0]   feeder_pos;
   logic            done, empty, read_fifo, out_valid, out_ready, finished;
   logic [N-1:0]    outlier_pos, out_x, out_y, out_z;
   logic [31:0]     run_cycles;

   point_cloud_feeder #(.N(N), .M(M), .CORE_NUMBER(CN), .MAX_POINTS(MAXP)) dut (
      .clock(clock), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
      .load_x(load_x), .load_y(load_y), .load_z(load_z), .load_last(load_last),
      .point_cloud_size(point_cloud_size), .ctrl_reset(ctrl_reset), .point_pos(point_pos),
      .cache_x(cache_x), .cache_y(cache_y), .cache_z(cache_z),
      .cache_feeder_x(cache_feeder_x), .cache_feeder_y(cache_feeder_y),
      .cache_feeder_z(cache_feeder_z), .feeder_pos(feeder_pos), .done(done), .empty(empty),
      .read_fifo(read_fifo), .outlier_pos(outlier_pos), .out_valid(out_valid),
      .out_ready(out_ready), .out_x(out_x), .out_y(out_y), .out_z(out_z),
      .finished(finished), .run_cycles(run_cycles));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   int n_checks = 0, n_fail = 0;
   logic [N-1:0]    mx[$], my[$], mz[$];
   logic [N-1:0]    fifo[$];
   logic [3*N-1:0]  exp_out[$];
   int              model_fp = 0;
   int              run_edges = 0;
   bit              seen64 = 0;

   task automatic check_eq(input string tag, input logic [N*M:0] got, input logic [N*M:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [3*N-1:0] ref_pt(input int idx);
      if (idx >= 0 && idx < mx.size()) return {mx[idx], my[idx], mz[idx]};
      return '0;
   endfunction

   function automatic int ref_next(input int fp);
      return (fp + M >= mx.size()) ? 0 : fp + M;
   endfunction

   function automatic logic [31:0] exp_runc();
`ifdef FEEDER_PERF_CNT_EN
      return 32'(run_edges);
`else
      return 32'd0;
`endif
   endfunction

   task automatic tick();
      logic rf;
      rf = read_fifo;
      @(posedge clock);
      #1;
      if (rf && fifo.size() > 0) outlier_pos = fifo.pop_front();
      empty = (fifo.size() == 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      mx.delete(); my.delete(); mz.delete();
      fifo.delete(); exp_out.delete();
      empty = 1'b1;
      model_fp = 0;
      run_edges = 0;
   endtask

   task automatic push_fifo(input logic [N-1:0] pos);
      fifo.push_back(pos);
      exp_out.push_back(ref_pt(int'(pos)));
      empty = 1'b0;
   endtask

   task automatic load_cloud(input int n, input bit seq_x, input bit gaps, input bit done_noise);
      logic [N-1:0] xv, yv, zv;
      for (int i = 0; i < n; i++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            load_valid = 1'b0;
            tick();
         end
         xv = seq_x ? N'(i + 1) : N'($urandom_range(1, 65535));
         yv = N'($urandom_range(1, 65535));
         zv = N'($urandom_range(1, 65535));
         load_valid = 1'b1; load_x = xv; load_y = yv; load_z = zv;
         load_last = (i == n - 1);
         done = done_noise && (i < n - 1);
         if (i == n - 1) check_eq("ctrl_reset_pre", ctrl_reset, 1);
         tick();
         mx.push_back(xv); my.push_back(yv); mz.push_back(zv);
      end
      load_valid = 1'b0; load_last = 1'b0; done = 1'b0;
      check_eq("ctrl_reset_drop", ctrl_reset, 0);
      check_eq("load_ready_run", load_ready, 0);
      check_eq("size", point_cloud_size, n);
      check_eq("feeder_pos_start", feeder_pos, 0);
   endtask

   task automatic run_step(input logic [N-1:0] pp, input logic dn);
      logic [N*M-1:0]  wx, wy, wz;
      logic [N*CN-1:0] cx, cy, cz;
      logic [3*N-1:0]  p;
      int              base, nz;
      point_pos = pp;
      done = dn;
      wx = '0; wy = '0; wz = '0; cx = '0; cy = '0; cz = '0;
      for (int i = 0; i < M; i++) begin
         p = ref_pt(model_fp + i);
         wx = {wx[N*M-N-1:0], p[3*N-1 -: N]};
         wy = {wy[N*M-N-1:0], p[2*N-1 -: N]};
         wz = {wz[N*M-N-1:0], p[N-1:0]};
      end
      for (int i = 0; i < CN; i++) begin
         p = ref_pt(int'(pp) + i);
         cx = {cx[N*CN-N-1:0], p[3*N-1 -: N]};
         cy = {cy[N*CN-N-1:0], p[2*N-1 -: N]};
         cz = {cz[N*CN-N-1:0], p[N-1:0]};
      end
      base = model_fp;
      tick();
      done = 1'b0;
      run_edges++;
      check_eq("cache_x", cache_x, cx);
      check_eq("cache_y", cache_y, cy);
      check_eq("cache_z", cache_z, cz);
      check_eq("window_x", cache_feeder_x, wx);
      check_eq("window_y", cache_feeder_y, wy);
      check_eq("window_z", cache_feeder_z, wz);
      model_fp = ref_next(model_fp);
      check_eq("feeder_pos", feeder_pos, model_fp);
      if (base == 64 && mx.size() == 70 && !seen64) begin
         seen64 = 1;
         nz = 0;
         for (int i = 0; i < M; i++) if (cache_feeder_x[N*(M-i)-1 -: N] != '0) nz++;
         check_eq("window64_valid_slots", nz, 6);
      end
   endtask

   task automatic drain(input int hold3);
      int hold_left, pulses, nexp;
      logic pv, pr, prf;
      logic [3*N-1:0] pd, e;
      hold_left = hold3; pulses = 0; nexp = exp_out.size();
      for (int c = 0; c < 400 && !finished; c++) begin
         if (out_valid && hold_left > 0) begin
            out_ready = 1'b0;
            hold_left--;
         end else begin
            out_ready = (hold3 > 0) ? 1'b1 : 1'($urandom_range(0, 1));
         end
         pv = out_valid; pr = out_ready; prf = read_fifo; pd = {out_x, out_y, out_z};
         if (prf) begin
            pulses++;
            check_eq("read_gated_by_valid", pv, 0);
         end
         if (pv && pr) begin
            if (exp_out.size() > 0) begin
               e = exp_out.pop_front();
               check_eq("out_xyz", pd, e);
            end else begin
               check_eq("extra_out", pv, 0);
            end
         end
         tick();
         if (pv && !pr) check_eq("out_hold", {out_valid, out_x, out_y, out_z}, {1'b1, pd});
         if (prf) check_eq("read_pulse_1cyc", read_fifo, 0);
      end
      out_ready = 1'b0;
      check_eq("finished", finished, 1);
      check_eq("read_pulses", pulses, nexp);
      check_eq("outs_left", exp_out.size(), 0);
      check_eq("fin_read_fifo", read_fifo, 0);
      check_eq("fin_out_valid", out_valid, 0);
   endtask

   initial begin
      reset = 1'b0; load_valid = 1'b0; load_last = 1'b0;
      load_x = '0; load_y = '0; load_z = '0;
      point_pos = '0; done = 1'b0; empty = 1'b1; outlier_pos = '0; out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;

      // Reset state
      do_reset();
      check_eq("rst_load_ready", load_ready, 1);
      check_eq("rst_ctrl_reset", ctrl_reset, 1);
      check_eq("rst_size", point_cloud_size, 0);
      check_eq("rst_read_fifo", read_fifo, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_finished", finished, 0);
      check_eq("rst_feeder_pos", feeder_pos, 0);
      check_eq("rst_cache_x", cache_x, 0);
      check_eq("rst_run_cycles", run_cycles, 0);

      // Phase 1: five points, request boundary, drain with back-pressure
      load_cloud(5, 1, 0, 0);
      run_step(16'd3, 0);
      check_eq("cache_x_pos3", cache_x, 32'h0004_0005);
      run_step(16'd4, 0);
      check_eq("cache_x_pos4", cache_x, 32'h0005_0000);
      for (int i = 0; i < 6; i++) run_step(N'($urandom_range(0, 7)), 0);
      push_fifo(16'd2);
      push_fifo(16'd0);
      run_step(16'd1, 1);
      drain(3);
      check_eq("run_cycles_p1", run_cycles, exp_runc());
      for (int i = 0; i < 3; i++) begin
         done = 1'b1;
         tick();
         check_eq("frozen_feeder", feeder_pos, model_fp);
         check_eq("frozen_finished", finished, 1);
      end
      done = 1'b0;

      // Phase 2: 70 points, window cycling, exactly 100 RUN cycles
      do_reset();
      load_cloud(70, 0, 1, 0);
      for (int i = 0; i < 99; i++) begin
         if (i % 10 == 0) run_step(N'(66 + $urandom_range(0, 6)), 0);
         else             run_step(N'($urandom_range(0, 80)), 0);
      end
      push_fifo(N'($urandom_range(0, 69)));
      push_fifo(16'd69);
      push_fifo(16'd75);
      push_fifo(N'($urandom_range(0, 69)));
      run_step(16'd69, 1);
      check_eq("run_cycles_100", run_cycles, exp_runc());
      drain(0);
      check_eq("run_cycles_held", run_cycles, exp_runc());

      // Phase 3: done/load_valid ignored in wrong states, reset mid-RUN
      do_reset();
      load_cloud(3, 0, 0, 1);
      load_valid = 1'b1; load_x = 16'h1234;
      run_step(16'd1, 0);
      run_step(16'd2, 0);
      load_valid = 1'b0;
      check_eq("size_ignores_load", point_cloud_size, 3);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_eq("midrun_load_ready", load_ready, 1);
      check_eq("midrun_ctrl_reset", ctrl_reset, 1);
      check_eq("midrun_size", point_cloud_size, 0);
      check_eq("midrun_feeder_pos", feeder_pos, 0);
      check_eq("midrun_cache_x", cache_x, 0);
      check_eq("midrun_run_cycles", run_cycles, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
